// File: rtl/mic1_mem_bridge.sv
// mic1_mem_bridge: byte-serial bridge between the MIC-1 core and the 8-bit
// external pins. It serialises word reads/writes (MAR/MDR) and byte fetches
// (PC/MBR) into address beats followed by data beats.
// Optional watchdog abort: define MIC1_BRIDGE_TIMEOUT_EN.
module mic1_mem_bridge (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic        req_fetch,
    input  logic [31:0] mar,
    input  logic [31:0] mdr_wr,
    input  logic [31:0] pc,
    output logic        busy,
    output logic        word_done,
    output logic [31:0] rdata,
    output logic        fetch_done,
    output logic [7:0]  fetch_data,
    output logic [7:0]  ext_dout,
    input  logic [7:0]  ext_din,
    output logic        ext_valid,
    input  logic        ext_ack,
    output logic [1:0]  ext_cmd,
    output logic        ext_last,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WADDR = 3'd1,
        S_WDATA = 3'd2,
        S_RDATA = 3'd3,
        S_FADDR = 3'd4,
        S_FDATA = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_ADDR  = 2'b01;
    localparam logic [1:0] CMD_WDATA = 2'b10;
    localparam logic [1:0] CMD_RDATA = 2'b11;

    // Architectural state
    state_t      r_state;
    logic [1:0]  r_cnt;
    logic [31:0] r_waddr;
    logic [31:0] r_wdata;
    logic [31:0] r_faddr;
    logic        r_is_write;
    logic        r_fetch_pend;

    // Registered outputs
    logic        r_busy;
    logic        r_word_done;
    logic [31:0] r_rdata;
    logic        r_fetch_done;
    logic [7:0]  r_fetch_data;
    logic [7:0]  r_dout;
    logic        r_valid;
    logic [1:0]  r_cmd;
    logic        r_last;

    // Next-state values
    state_t      w_state_next;
    logic [1:0]  w_cnt_next;
    logic [31:0] w_waddr_next;
    logic [31:0] w_wdata_next;
    logic [31:0] w_faddr_next;
    logic        w_is_write_next;
    logic        w_fetch_pend_next;
    logic        w_word_done_next;
    logic [31:0] w_rdata_next;
    logic        w_fetch_done_next;
    logic [7:0]  w_fetch_data_next;
    logic [7:0]  w_dout_next;
    logic        w_valid_next;
    logic [1:0]  w_cmd_next;
    logic        w_last_next;

    logic        w_beat;
    logic        w_abort;
    logic        w_unused;

    // Top two MAR bits fall off the word-to-byte address shift.
    assign w_unused = &{1'b0, mar[31:30]};

    // A beat completes when offered and accepted; ena gating is in the register stage.
    assign w_beat = r_valid & ext_ack;

`ifdef MIC1_BRIDGE_TIMEOUT_EN
    logic [7:0] r_wdog;
    logic       r_err;
    logic       w_stall;

    assign w_stall = r_valid & ~ext_ack;
    // The 255th consecutive stalled cycle aborts the transaction.
    assign w_abort = w_stall && (r_wdog == 8'd254);

    // Watchdog counter of consecutive stalled beats and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wdog <= 8'd0;
            r_err  <= 1'b0;
        end else if (ena) begin
            if (w_abort) begin
                r_wdog <= 8'd0;
                r_err  <= 1'b1;
            end else if (w_stall) begin
                r_wdog <= r_wdog + 8'd1;
            end else begin
                r_wdog <= 8'd0;
            end
        end
    end

    assign err = r_err;
`else
    assign w_abort = 1'b0;
    assign err     = 1'b0;
`endif

    // Byte lanes of the latched words, indexed by the beat counter.
    logic [7:0] w_waddr_lane [4];
    logic [7:0] w_wdata_lane [4];
    logic [7:0] w_faddr_lane [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_waddr_lane[gi] = w_waddr_next[8*gi +: 8];
            assign w_wdata_lane[gi] = w_wdata_next[8*gi +: 8];
            assign w_faddr_lane[gi] = w_faddr_next[8*gi +: 8];
        end
    endgenerate

    // Next-state logic: request capture, beat sequencing, data capture, abort.
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_waddr_next      = r_waddr;
        w_wdata_next      = r_wdata;
        w_faddr_next      = r_faddr;
        w_is_write_next   = r_is_write;
        w_fetch_pend_next = r_fetch_pend;
        w_rdata_next      = r_rdata;
        w_fetch_data_next = r_fetch_data;
        w_word_done_next  = 1'b0;
        w_fetch_done_next = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (req_wr || req_rd) begin
                    // Write wins over a simultaneous read; a fetch rides along.
                    w_waddr_next      = {mar[29:0], 2'b00};
                    w_wdata_next      = mdr_wr;
                    w_faddr_next      = pc;
                    w_is_write_next   = req_wr;
                    w_fetch_pend_next = req_fetch;
                    w_cnt_next        = 2'd0;
                    w_state_next      = S_WADDR;
                end else if (req_fetch) begin
                    w_waddr_next      = {mar[29:0], 2'b00};
                    w_wdata_next      = mdr_wr;
                    w_faddr_next      = pc;
                    w_is_write_next   = 1'b0;
                    w_fetch_pend_next = 1'b0;
                    w_cnt_next        = 2'd0;
                    w_state_next      = S_FADDR;
                end
            end
            S_WADDR: begin
                if (w_beat) begin
                    if (r_cnt == 2'd3) begin
                        w_cnt_next   = 2'd0;
                        w_state_next = r_is_write ? S_WDATA : S_RDATA;
                    end else begin
                        w_cnt_next = r_cnt + 2'd1;
                    end
                end
            end
            S_WDATA, S_RDATA: begin
                if (w_beat) begin
                    if (r_state == S_RDATA) begin
                        w_rdata_next[{r_cnt, 3'b000} +: 8] = ext_din;
                    end
                    if (r_cnt == 2'd3) begin
                        w_cnt_next        = 2'd0;
                        w_word_done_next  = 1'b1;
                        w_fetch_pend_next = 1'b0;
                        w_state_next      = r_fetch_pend ? S_FADDR : S_DONE;
                    end else begin
                        w_cnt_next = r_cnt + 2'd1;
                    end
                end
            end
            S_FADDR: begin
                if (w_beat) begin
                    if (r_cnt == 2'd3) begin
                        w_cnt_next   = 2'd0;
                        w_state_next = S_FDATA;
                    end else begin
                        w_cnt_next = r_cnt + 2'd1;
                    end
                end
            end
            S_FDATA: begin
                if (w_beat) begin
                    w_fetch_data_next = ext_din;
                    w_fetch_done_next = 1'b1;
                    w_state_next      = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 2'd0;
            end
        endcase

        // Watchdog abort closes out whichever operation is on the bus.
        if (w_abort) begin
            w_rdata_next      = 32'hFFFF_FFFF;
            w_fetch_data_next = 8'hFF;
            w_word_done_next  = (r_state == S_WADDR) || (r_state == S_WDATA) ||
                                (r_state == S_RDATA);
            w_fetch_done_next = (r_state == S_FADDR) || (r_state == S_FDATA);
            w_fetch_pend_next = 1'b0;
            w_cnt_next        = 2'd0;
            w_state_next      = S_DONE;
        end
    end

    // Bus-side output decode from the upcoming state so the pins come straight from flops.
    always_comb begin
        w_valid_next = 1'b0;
        w_cmd_next   = CMD_IDLE;
        w_dout_next  = 8'h00;
        w_last_next  = 1'b0;
        case (w_state_next)
            S_WADDR: begin
                w_valid_next = 1'b1;
                w_cmd_next   = CMD_ADDR;
                w_dout_next  = w_waddr_lane[w_cnt_next];
                w_last_next  = (w_cnt_next == 2'd3);
            end
            S_WDATA: begin
                w_valid_next = 1'b1;
                w_cmd_next   = CMD_WDATA;
                w_dout_next  = w_wdata_lane[w_cnt_next];
                w_last_next  = (w_cnt_next == 2'd3);
            end
            S_RDATA: begin
                w_valid_next = 1'b1;
                w_cmd_next   = CMD_RDATA;
                w_last_next  = (w_cnt_next == 2'd3);
            end
            S_FADDR: begin
                w_valid_next = 1'b1;
                w_cmd_next   = CMD_ADDR;
                w_dout_next  = w_faddr_lane[w_cnt_next];
                w_last_next  = (w_cnt_next == 2'd3);
            end
            S_FDATA: begin
                w_valid_next = 1'b1;
                w_cmd_next   = CMD_RDATA;
                w_last_next  = 1'b1;
            end
            default: begin
                w_valid_next = 1'b0;
            end
        endcase
    end

    // State and output registers; everything freezes while ena is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 2'd0;
            r_waddr      <= 32'd0;
            r_wdata      <= 32'd0;
            r_faddr      <= 32'd0;
            r_is_write   <= 1'b0;
            r_fetch_pend <= 1'b0;
            r_busy       <= 1'b0;
            r_word_done  <= 1'b0;
            r_rdata      <= 32'd0;
            r_fetch_done <= 1'b0;
            r_fetch_data <= 8'd0;
            r_dout       <= 8'd0;
            r_valid      <= 1'b0;
            r_cmd        <= CMD_IDLE;
            r_last       <= 1'b0;
        end else if (ena) begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_waddr      <= w_waddr_next;
            r_wdata      <= w_wdata_next;
            r_faddr      <= w_faddr_next;
            r_is_write   <= w_is_write_next;
            r_fetch_pend <= w_fetch_pend_next;
            r_busy       <= (w_state_next != S_IDLE);
            r_word_done  <= w_word_done_next;
            r_rdata      <= w_rdata_next;
            r_fetch_done <= w_fetch_done_next;
            r_fetch_data <= w_fetch_data_next;
            r_dout       <= w_dout_next;
            r_valid      <= w_valid_next;
            r_cmd        <= w_cmd_next;
            r_last       <= w_last_next;
        end
    end

    assign busy       = r_busy;
    assign word_done  = r_word_done;
    assign rdata      = r_rdata;
    assign fetch_done = r_fetch_done;
    assign fetch_data = r_fetch_data;
    assign ext_dout   = r_dout;
    assign ext_valid  = r_valid;
    assign ext_cmd    = r_cmd;
    assign ext_last   = r_last;

endmodule

// File: tb/tb_mic1_mem_bridge.sv
// Scoreboard bench for mic1_mem_bridge: stimulus pushes expected beats and
// completions derived from the bridge's protocol rules; a negedge monitor
// pops and compares whenever the bridge completes a beat or pulses a done.
// Cycle n is the clock period that ends at rising edge n.
module tb_mic1_mem_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        req_rd = 1'b0;
    logic        req_wr = 1'b0;
    logic        req_fetch = 1'b0;
    logic [31:0] mar = 32'd0;
    logic [31:0] mdr_wr = 32'd0;
    logic [31:0] pc = 32'd0;
    logic        busy;
    logic        word_done;
    logic [31:0] rdata;
    logic        fetch_done;
    logic [7:0]  fetch_data;
    logic [7:0]  ext_dout;
    logic [7:0]  ext_din = 8'd0;
    logic        ext_valid;
    logic        ext_ack = 1'b0;
    logic [1:0]  ext_cmd;
    logic        ext_last;
    logic        err;

    mic1_mem_bridge dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .req_rd     (req_rd),
        .req_wr     (req_wr),
        .req_fetch  (req_fetch),
        .mar        (mar),
        .mdr_wr     (mdr_wr),
        .pc         (pc),
        .busy       (busy),
        .word_done  (word_done),
        .rdata      (rdata),
        .fetch_done (fetch_done),
        .fetch_data (fetch_data),
        .ext_dout   (ext_dout),
        .ext_din    (ext_din),
        .ext_valid  (ext_valid),
        .ext_ack    (ext_ack),
        .ext_cmd    (ext_cmd),
        .ext_last   (ext_last),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] cmd;
        logic [7:0] dout;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic        is_word;
        logic [31:0] data;
    } done_t;

    beat_t       beat_q [$];
    done_t       done_q [$];
    logic [7:0]  din_q  [$];

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          ack_mode = 0;   // 0: ack tied high, 1: random, 2: refuse read beats
    logic [31:0] rdata_model = 32'd0;
    int          last_wd_cyc = -1;
    int          last_fd_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected at cycle %0d", name, cyc);
    endtask

    // Four LSB-first beats of a word; read beats carry 0 on dout.
    task automatic push_bytes(input logic [1:0] cmd, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            beat_q.push_back('{cmd: cmd, dout: (cmd == 2'b11) ? 8'h00 : w[8*i +: 8], last: (i == 3)});
        end
    endtask

    // Reference model of one accepted request.
    task automatic plan(input logic rd, input logic wr, input logic f,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] p,
                        input logic [31:0] rb, input logic [7:0] fb);
        if (rd || wr) begin
            push_bytes(2'b01, {a[29:0], 2'b00});
            if (wr) begin
                push_bytes(2'b10, d);
            end else begin
                push_bytes(2'b11, 32'h0);
                for (int i = 0; i < 4; i++) din_q.push_back(rb[8*i +: 8]);
                rdata_model = rb;
            end
            done_q.push_back('{is_word: 1'b1, data: rdata_model});
        end
        if (f) begin
            push_bytes(2'b01, p);
            beat_q.push_back('{cmd: 2'b11, dout: 8'h00, last: 1'b1});
            din_q.push_back(fb);
            done_q.push_back('{is_word: 1'b0, data: {24'h0, fb}});
        end
    endtask

    // Called just after a rising edge; the request is sampled at edge k.
    task automatic issue(input logic rd, input logic wr, input logic f,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] p,
                         input logic [31:0] rb, input logic [7:0] fb, output int k);
        req_rd = rd; req_wr = wr; req_fetch = f;
        mar = a; mdr_wr = d; pc = p;
        k = cyc + 1;
        plan(rd, wr, f, a, d, p, rb, fb);
        $display("txn @%0d: rd=%0b wr=%0b fetch=%0b mar=%h mdr=%h pc=%h", k, rd, wr, f, a, d, p);
        @(posedge clk); #1;
        req_rd = 1'b0; req_wr = 1'b0; req_fetch = 1'b0;
    endtask

    // Wait until the bridge is idle with nothing outstanding; returns the first idle cycle.
    task automatic wait_idle(input int budget, output int idle_cyc);
        int n;
        n = 0;
        idle_cyc = -1;
        forever begin
            @(negedge clk);
            if (!busy && beat_q.size() == 0 && done_q.size() == 0) begin
                idle_cyc = cyc + 1;
                break;
            end
            n++;
            if (n > budget) begin
                fail_now("wait_idle_timeout");
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_word_done"},  word_done,  0);
        check({tag, "_fetch_done"}, fetch_done, 0);
        check({tag, "_rdata"},      rdata,      0);
        check({tag, "_fetch_data"}, fetch_data, 0);
        check({tag, "_ext_dout"},   ext_dout,   0);
        check({tag, "_ext_valid"},  ext_valid,  0);
        check({tag, "_ext_cmd"},    ext_cmd,    0);
        check({tag, "_ext_last"},   ext_last,   0);
        check({tag, "_err"},        err,        0);
    endtask

    // External memory responder: drives ack and the next planned read byte.
    initial begin
        forever begin
            @(posedge clk); #1;
            case (ack_mode)
                0:       ext_ack = 1'b1;
                1:       ext_ack = 1'($urandom_range(0, 1));
                default: ext_ack = (ext_cmd != 2'b11);
            endcase
            ext_din = (din_q.size() > 0) ? din_q[0] : 8'($urandom);
        end
    end

    // Monitor: compares completed beats, stall stability and done pulses.
    logic       hold = 1'b0;
    logic [7:0] hold_dout = 8'd0;
    logic [1:0] hold_cmd = 2'd0;
    logic       hold_last = 1'b0;

    always @(negedge clk) begin
        beat_t b;
        done_t d;
        if (!rst_n) begin
            hold <= 1'b0;
        end else begin
            if (hold && ext_valid) begin
                check("stall_stable", {ext_cmd, ext_dout, ext_last}, {hold_cmd, hold_dout, hold_last});
            end
            if (ext_valid && ena && ext_ack) begin
                if (beat_q.size() == 0) begin
                    fail_now("beat_unexpected");
                end else begin
                    b = beat_q.pop_front();
                    check("beat", {ext_cmd, ext_dout, ext_last}, b);
                    if (b.cmd == 2'b11 && din_q.size() > 0) void'(din_q.pop_front());
                end
            end
            hold      <= ext_valid && !(ena && ext_ack);
            hold_dout <= ext_dout;
            hold_cmd  <= ext_cmd;
            hold_last <= ext_last;
            if (word_done) begin
                last_wd_cyc = cyc + 1;
                if (done_q.size() == 0) begin
                    fail_now("word_done_unexpected");
                end else begin
                    d = done_q.pop_front();
                    check("word_done_kind", 1'b1, d.is_word);
                    check("rdata", rdata, d.data);
                end
            end
            if (fetch_done) begin
                last_fd_cyc = cyc + 1;
                if (done_q.size() == 0) begin
                    fail_now("fetch_done_unexpected");
                end else begin
                    d = done_q.pop_front();
                    check("fetch_done_kind", 1'b0, d.is_word);
                    check("fetch_data", fetch_data, d.data[7:0]);
                end
            end
        end
    end

    // Absolute time limit.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int k;
        int idle_c;
        int n;
        logic found;
        logic rd, wr, f;

        rst_n = 1'b0;
        ena = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed read, ack tied high.
        ack_mode = 0;
        issue(1, 0, 0, 32'h0000_0010, 32'h0, 32'h0, 32'h4433_2211, 8'h00, k);
        wait_idle(100, idle_c);
        check("rd_word_done_cycle", last_wd_cyc, k + 9);
        check("rd_idle_cycle", idle_c, k + 10);

        // Directed write.
        issue(0, 1, 0, 32'h0000_0001, 32'hDEAD_BEEF, 32'h0, 32'h0, 8'h00, k);
        wait_idle(100, idle_c);
        check("wr_word_done_cycle", last_wd_cyc, k + 9);
        check("wr_idle_cycle", idle_c, k + 10);

        // Read plus fetch.
        issue(1, 0, 1, 32'h0000_0040, 32'h0, 32'h0000_0123, 32'h8877_6655, 8'h5A, k);
        wait_idle(100, idle_c);
        check("rdf_word_done_cycle", last_wd_cyc, k + 9);
        check("rdf_fetch_done_cycle", last_fd_cyc, k + 14);
        check("rdf_idle_cycle", idle_c, k + 15);

        // Fetch alone.
        issue(0, 0, 1, 32'h0, 32'h0, 32'hCAFE_0001, 32'h0, 8'hA5, k);
        wait_idle(100, idle_c);
        check("f_fetch_done_cycle", last_fd_cyc, k + 6);
        check("f_idle_cycle", idle_c, k + 7);

        // Random ack with ena low for three cycles once read data starts.
        ack_mode = 1;
        issue(1, 0, 0, $urandom, 32'h0, 32'h0, $urandom, 8'h00, k);
        found = 1'b0;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ext_cmd == 2'b11) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) fail_now("ena_test_rdata_phase");
        @(posedge clk); #1;
        ena = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ena = 1'b1;
        wait_idle(400, idle_c);

        // Read and write together (write wins), plus a request while busy.
        ack_mode = 0;
        issue(1, 1, 0, 32'h1234_5678, 32'h0BAD_F00D, 32'h0, 32'h0, 8'h00, k);
        repeat (3) @(posedge clk);
        #1;
        req_rd = 1'b1;
        req_fetch = 1'b1;
        mar = 32'h5555_5555;
        @(posedge clk); #1;
        req_rd = 1'b0;
        req_fetch = 1'b0;
        wait_idle(100, idle_c);

        // Reset in the middle of the write data phase.
        ack_mode = 1;
        issue(0, 1, 0, $urandom, $urandom, 32'h0, 32'h0, 8'h00, k);
        found = 1'b0;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ext_cmd == 2'b10) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) fail_now("rst_test_wdata_phase");
        @(posedge clk); #1;
        rst_n = 1'b0;
        beat_q.delete();
        done_q.delete();
        din_q.delete();
        rdata_model = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_still_idle", busy, 0);

        // Randomised mix of requests with random ack.
        ack_mode = 1;
        for (int t = 0; t < 24; t++) begin
            rd = 1'($urandom);
            wr = 1'($urandom);
            f  = 1'($urandom);
            if (!rd && !wr && !f) f = 1'b1;
            issue(rd, wr, f, $urandom, $urandom, $urandom, $urandom, 8'($urandom), k);
            wait_idle(400, idle_c);
        end

`ifdef MIC1_BRIDGE_TIMEOUT_EN
        // Read data never acknowledged: watchdog aborts the word read.
        ack_mode = 2;
        req_rd = 1'b1;
        mar = 32'h0000_0100;
        k = cyc + 1;
        push_bytes(2'b01, {mar[29:0], 2'b00});
        rdata_model = 32'hFFFF_FFFF;
        done_q.push_back('{is_word: 1'b1, data: rdata_model});
        $display("txn @%0d: rd=1 with read data stalled", k);
        @(posedge clk); #1;
        req_rd = 1'b0;
        wait_idle(600, idle_c);
        check("to_word_done_cycle", last_wd_cyc, k + 260);
        check("to_err", err, 1);
        ack_mode = 1;
`else
        check("err_compiled_out", err, 0);
`endif

        repeat (4) @(posedge clk);
        check("beat_q_empty", beat_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mic1_mem_bridge.md
# mic1_mem_bridge

Byte-serial memory bridge between the MIC-1 datapath and the 8-bit external pins. It accepts 32-bit word read/write requests (MAR/MDR) and byte instruction fetches (PC/MBR) from the CPU core. Each request is serialized into a beat-level handshake protocol: address bytes first, then data bytes. The bridge sits directly below the CPU core and drives `uo_out`/`ui_in` through the top-level wrapper.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low; clock `clk`.
- `ena` in 1: when low, the FSM, counters and outputs hold their values.
- `req_rd` in 1: word read request; sampled in IDLE only.
- `req_wr` in 1: word write request; sampled in IDLE only.
- `req_fetch` in 1: byte fetch request; sampled in IDLE only.
- `mar` in 32: word address for read/write.
- `mdr_wr` in 32: write data.
- `pc` in 32: byte address for fetch.
- `busy` out 1: high in every state except IDLE.
- `word_done` out 1: one-cycle pulse when a read or write completes.
- `rdata` out 32: assembled read data; valid when `word_done` follows a read.
- `fetch_done` out 1: one-cycle pulse when a fetch completes.
- `fetch_data` out 8: fetched byte.
- `ext_dout` out 8: outgoing byte (address or write data).
- `ext_din` in 8: incoming read byte.
- `ext_valid` out 1: beat offered.
- `ext_ack` in 1: beat accepted this cycle.
- `ext_cmd` out 2: beat type. 00 idle, 01 address, 10 write data, 11 read data.
- `ext_last` out 1: final beat of the current phase.
- `err` out 1: sticky timeout flag; reads 0 when the timeout feature is compiled out.

## Operation
- **States:**
  - IDLE
  - WADDR: 4 beats
  - WDATA: 4 beats
  - RDATA: 4 beats
  - FADDR: 4 beats
  - FDATA: 1 beat
  - DONE
- **Request capture in IDLE** (with `ena`=1):
  - Latch `mar`, `mdr_wr`, `pc`, the word-op kind and a pending-fetch bit.
  - `req_wr` and `req_rd` together: write wins and the read is dropped.
  - Any word request goes to WADDR. A fetch alone goes to FADDR.
- **Addresses:**
  - Word byte address = `{mar[29:0],2'b00}` (drop the top 2 bits).
  - Fetch address = `pc`.
  - Sent LSB first: beat i carries bits [8i+7:8i].
- **Beat rules:**
  - A beat completes on a rising edge where `ext_valid`=1 and `ext_ack`=1.
  - A 2-bit beat counter advances only on completion.
  - `ext_last`=1 when the counter is 3, and on the single FDATA beat.
  - `ext_dout` is constant while a beat is pending. It is 0 during read beats.
- **Phase transitions:**
  - After the last WADDR beat: to WDATA for a write, RDATA for a read.
  - WDATA sends `mdr_wr` LSB first.
  - RDATA: beat i writes `ext_din` into `rdata[8i+7:8i]`. Other bytes keep their previous value until overwritten.
  - After the last WDATA/RDATA beat: pulse `word_done`. If the fetch is pending, go to FADDR; otherwise go to DONE.
  - FDATA captures `ext_din` into `fetch_data` and pulses `fetch_done`, then goes to DONE.
- **DONE:** one cycle, `ext_valid`=0, then back to IDLE.
- `word_done`/`fetch_done` are asserted in the cycle after the completing edge.
- Requests arriving while `busy`=1 are ignored. The core must hold or reissue them.
- `ena` low mid-beat: the beat does not complete even if `ext_ack`=1.

## Timing
- Reset values: IDLE, counter 0. These outputs are all 0: `busy`, `word_done`, `fetch_done`, `rdata`, `fetch_data`, `ext_dout`, `ext_valid`, `ext_cmd`, `ext_last`, `err`.
- Reset mid-transaction: aborts, no done pulse, back to IDLE next cycle.
- Latency with `ext_ack` tied 1 and request sampled at edge k:
  - Read/write: `word_done` in cycle k+9, IDLE at k+10.
  - Fetch alone: `fetch_done` at k+6, IDLE at k+7.
  - Read+fetch: `word_done` at k+9, `fetch_done` at k+14, IDLE at k+15.
- Each `ext_ack` low cycle adds one cycle.
- All outputs are registered. No combinational path from `ext_ack` or `ext_din` to outputs.

## Configuration
- `MIC1_BRIDGE_TIMEOUT_EN` defined:
  - An 8-bit watchdog counts consecutive cycles with `ext_valid`=1 and `ext_ack`=0.
  - At 255 the transaction aborts: `err` set (sticky until reset), `rdata`=32'hFFFFFFFF, `fetch_data`=8'hFF.
  - The done pulse for the active operation fires, any pending fetch is dropped, and the FSM goes to DONE.
  - The counter resets on every completed beat.
- Undefined: no watchdog; the bridge waits on `ext_ack` indefinitely; `err` is tied 0.

## Test plan
- Reset, then `req_rd` with `mar`=32'h00000010, `ext_ack`=1 and `ext_din` supplying 11,22,33,44 → address beats 40,00,00,00 with `ext_cmd`=01; `rdata`=32'h44332211 with `word_done` at k+9.
- `req_wr` with `mar`=1, `mdr_wr`=32'hDEADBEEF → address beats 04,00,00,00, then data beats EF,BE,AD,DE with `ext_cmd`=10; `ext_last` on beats 3 and 7.
- `req_rd` and `req_fetch` together with `pc`=32'h00000123 → word read completes first, then fetch address beats 23,01,00,00 and one data beat; `fetch_done` at k+14.
- `ext_ack` toggling randomly plus `ena` low for 3 cycles mid-RDATA → `rdata` correct, `ext_dout` stable while stalled, no duplicated beats.
- `req_rd`/`req_wr` together; new request while busy; `rst_n` low mid-WDATA → write-only transaction; busy-time request ignored; after reset, IDLE with all outputs 0 and no done pulse.
- With `MIC1_BRIDGE_TIMEOUT_EN`: `ext_ack` held 0 during RDATA → abort after 255 stall cycles; `err`=1, `rdata`=32'hFFFFFFFF, `word_done` pulses.
